// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one bus read outstanding,
// and hands {instr, pc} to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic [XLEN-1:0]   pend_pc, pend_pc_nxt;
    logic              discard, discard_nxt;
    logic [XLEN-1:0]   instr_nxt;
    logic [XLEN-1:0]   opc_nxt;
    logic [XLEN-1:0]   redir_target;
    logic [XLEN-1:0]   pc_inc;

    assign redir_target = redirect_pc & ~XLEN'(3);
    assign pc_inc       = pc + XLEN'(4);

    // Moore outputs decoded from the state and PC registers
    assign ireq_valid = (state == S_REQ);
    assign ireq_addr  = pc;
    assign out_valid  = (state == S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            discard    <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
            discard    <= discard_nxt;
            out_instr  <= instr_nxt;
            out_pc     <= opc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        discard_nxt    = discard;
        instr_nxt      = out_instr;
        opc_nxt        = out_pc;

        case (state)
            S_BOOT: begin
                state_nxt = S_REQ;
                if (redirect_valid) pc_nxt = redir_target;
            end

            // REQ with addr_ok behaves like WAIT in the same cycle
            S_REQ, S_WAIT: begin
                if (state == S_REQ && !iresp_addr_ok) begin
                    // address must stay put until accepted; remember the redirect
                    if (redirect_valid) begin
                        pend_valid_nxt = 1'b1;
                        pend_pc_nxt    = redir_target;
                        discard_nxt    = 1'b1;
                    end
                end else if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        state_nxt      = S_REQ;
                        pc_nxt         = redir_target;
                        pend_valid_nxt = 1'b0;
                        discard_nxt    = 1'b0;
                    end else if (discard) begin
                        state_nxt      = S_REQ;
                        pc_nxt         = pend_pc;
                        pend_valid_nxt = 1'b0;
                        discard_nxt    = 1'b0;
                    end else begin
                        state_nxt = S_HOLD;
                        instr_nxt = iresp_data;
                        opc_nxt   = pc;
                    end
                end else begin
                    state_nxt = S_WAIT;
                    if (redirect_valid) begin
                        pend_valid_nxt = 1'b1;
                        pend_pc_nxt    = redir_target;
                        discard_nxt    = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    state_nxt      = S_REQ;
                    pc_nxt         = redir_target;
                    pend_valid_nxt = 1'b0;
                end else if (out_ready) begin
                    state_nxt      = S_REQ;
                    pc_nxt         = pend_valid ? pend_pc : pc_inc;
                    pend_valid_nxt = 1'b0;
                end
            end

            default: state_nxt = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: driver pushes expected bus requests and
// deliveries into queues; a negedge monitor pops and compares them.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_req[$];
    logic [63:0] exp_out[$];
    logic [31:0] last_addr;

    fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1ns after the edge that consumed them.
    // The bus returns ~address as the instruction word.
    task automatic tick(input logic a, input logic d, input logic r,
                        input logic rv = 1'b0, input logic [31:0] rpc = 32'h0);
        logic [31:0] src;
        src = a ? ireq_addr : last_addr;
        if (a) last_addr = ireq_addr;
        iresp_addr_ok  = a;
        iresp_data_ok  = d;
        iresp_data     = d ? ~src : 32'hdead_beef;
        out_ready      = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] instr);
        exp_req.push_back(addr);
        exp_out.push_back({addr, instr});
    endtask

    // Monitor: compares accepted requests and delivered instructions
    initial begin
        logic [31:0] ea;
        logic [63:0] eo;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ireq_valid && iresp_addr_ok) begin
                    if (exp_req.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got %08h expected none", ireq_addr);
                    end else begin
                        ea = exp_req.pop_front();
                        chk("req_addr", ireq_addr, ea);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out: got pc %08h instr %08h expected none", out_pc, out_instr);
                    end else begin
                        eo = exp_out.pop_front();
                        chk("out_pc", out_pc, eo[63:32]);
                        chk("out_instr", out_instr, eo[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] addr;
        reset = 1'b1;
        last_addr = 32'h0;
        iresp_addr_ok = 0; iresp_data_ok = 0; iresp_data = 0;
        out_ready = 0; redirect_valid = 0; redirect_pc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", 32'(ireq_valid), 32'h0);
        chk("rst_ireq_addr", ireq_addr, 32'hbfc0_0000);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait bus, decode always ready
        tick(0, 0, 1);
        chk("boot_req_valid", 32'(ireq_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            addr = 32'hbfc0_0000 + 32'(i * 4);
            expect_fetch(addr, ~addr);
            chk("seq_addr", ireq_addr, addr);
            tick(1, 0, 1);
            chk("seq_wait_novalid", 32'(out_valid), 32'h0);
            tick(0, 1, 1);
            chk("seq_hold_valid", 32'(out_valid), 32'h1);
            tick(0, 0, 1);
        end

        // Decode stall for 5 cycles
        expect_fetch(32'hbfc0_000c, 32'h403f_fff3);
        tick(1, 0, 0);
        tick(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_pc", out_pc, 32'hbfc0_000c);
            chk("stall_instr", out_instr, 32'h403f_fff3);
            chk("stall_noreq", 32'(ireq_valid), 32'h0);
        end
        tick(0, 0, 1);

        // Redirect while waiting for data
        exp_req.push_back(32'hbfc0_0010);
        tick(1, 0, 1);
        tick(0, 0, 1, 1, 32'h8000_1000);
        tick(0, 1, 1);
        chk("wait_redir_addr", ireq_addr, 32'h8000_1000);
        chk("wait_redir_valid", 32'(ireq_valid), 32'h1);
        expect_fetch(32'h8000_1000, 32'h7fff_efff);
        tick(1, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);

        // Asynchronous reset mid-WAIT
        exp_req.push_back(32'h8000_1004);
        tick(1, 0, 1);
        iresp_addr_ok = 0; out_ready = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_ireq_valid", 32'(ireq_valid), 32'h0);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_ireq_addr", ireq_addr, 32'hbfc0_0000);
        @(negedge clk);
        reset = 1'b0;
        tick(0, 0, 1);
        chk("restart_addr", ireq_addr, 32'hbfc0_0000);
        // addr_ok and data_ok together: out_valid one cycle later
        expect_fetch(32'hbfc0_0000, 32'h403f_ffff);
        tick(1, 1, 1);
        chk("fast_hold_valid", 32'(out_valid), 32'h1);
        tick(0, 0, 1);

        // Redirect while the request is not yet accepted
        tick(0, 0, 1, 1, 32'h8000_2000);
        chk("req_hold_addr", ireq_addr, 32'hbfc0_0004);
        tick(0, 0, 1);
        chk("req_hold_addr2", ireq_addr, 32'hbfc0_0004);
        exp_req.push_back(32'hbfc0_0004);
        tick(1, 0, 1);
        tick(0, 1, 1);
        chk("req_redir_addr", ireq_addr, 32'h8000_2000);
        expect_fetch(32'h8000_2000, 32'h7fff_dfff);
        tick(1, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);

        // Redirect together with out_ready in HOLD: delivered once
        expect_fetch(32'h8000_2004, 32'h7fff_dffb);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 1, 1, 32'hbfc0_0008);
        expect_fetch(32'hbfc0_0008, 32'h403f_fff7);
        tick(1, 0, 0);
        tick(0, 1, 0);
        chk("hold_pc", out_pc, 32'hbfc0_0008);
        tick(0, 0, 1, 1, 32'h8000_3003);
        chk("hold_redir_addr", ireq_addr, 32'h8000_3000);
        expect_fetch(32'h8000_3000, 32'h7fff_cfff);
        tick(1, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);

        // Redirect in HOLD without ready drops the instruction
        exp_req.push_back(32'h8000_3004);
        tick(1, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0, 1, 32'hbfc0_0100);
        chk("drop_out_valid", 32'(out_valid), 32'h0);
        chk("drop_addr", ireq_addr, 32'hbfc0_0100);

        // Redirect coinciding with data_ok: data dropped, then wrap past 2^32
        exp_req.push_back(32'hbfc0_0100);
        tick(1, 0, 1);
        tick(0, 1, 1, 1, 32'hffff_fffc);
        chk("coinc_addr", ireq_addr, 32'hffff_fffc);
        expect_fetch(32'hffff_fffc, 32'h0000_0003);
        tick(1, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);
        chk("wrap_addr", ireq_addr, 32'h0000_0000);
        tick(0, 0, 0);

        chk("req_queue_empty", 32'(exp_req.size()), 32'h0);
        chk("out_queue_empty", 32'(exp_out.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the mycpu pipeline. It owns the PC, issues one instruction-bus read at a time, buffers the returned word, and presents `{instr, pc}` to the decode stage through a valid/ready handshake. It accepts control-flow redirects from decode and squashes any fetch that has not yet been delivered.

## Interface
- `RESET_PC`, default `32'hbfc0_0000`: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ireq_valid` out 1: instruction-bus request valid.
- `ireq_addr` out 32: request address; always word aligned.
- `iresp_addr_ok` in 1: request accepted by the bus this cycle.
- `iresp_data_ok` in 1: read data returned this cycle.
- `iresp_data` in 32: read data, valid when `iresp_data_ok`=1.
- `redirect_valid` in 1: one-cycle pulse from decode meaning "next fetch is `redirect_pc`".
- `redirect_pc` in 32: redirect target.
- `out_valid` out 1: `out_instr`/`out_pc` hold a deliverable instruction.
- `out_ready` in 1: decode accepts the instruction this cycle.
- `out_instr` out 32: fetched instruction word.
- `out_pc` out 32: address it was fetched from.

## Operation
- Registers: `state`, `pc`, `pend_valid`, `pend_pc`, `discard`, `out_instr`, `out_pc`.
- States:
  - BOOT: post-reset idle.
  - REQ: `ireq_valid`=1, `ireq_addr`=`pc`.
  - WAIT: address accepted, awaiting data.
  - HOLD: `out_valid`=1.
- All outputs are decoded from registers only (Moore). There are no combinational in→out paths.
- Transitions:
  - BOOT→REQ: unconditional.
  - REQ: stays in REQ while `iresp_addr_ok`=0. On addr_ok with data_ok=0 → WAIT. On addr_ok and data_ok in the same cycle → treated as WAIT+data_ok below.
  - WAIT: stays in WAIT while data_ok=0. On data_ok with `discard`=0 → HOLD, latching `out_instr`=`iresp_data` and `out_pc`=`pc`. On data_ok with `discard`=1 → REQ with `pc`=`pend_pc`; `discard` and `pend_valid` are cleared.
  - HOLD: on `out_ready`=1 → REQ with `pc`=`pend_valid ? pend_pc : pc+4`; `pend_valid` is cleared.
- Redirect handling (`redirect_valid`=1 in state X):
  - REQ: `ireq_addr` must not change while `ireq_valid`=1 and not accepted. The redirect is recorded as `pend_valid`=1, `pend_pc`=`redirect_pc`, and `discard` is set. The in-flight fetch is completed on the bus and its data dropped.
  - WAIT: set `pend_*` and `discard`.
  - HOLD without `out_ready`: the held instruction is dropped. Next state is REQ with `pc`=`redirect_pc` and `out_valid`=0.
  - HOLD with `out_ready`: the held instruction counts as delivered. Next state is REQ with `pc`=`redirect_pc`.
  - BOOT: `pc`=`redirect_pc`.
- Repeated redirects: the last one wins (`pend_pc` is overwritten).
- Redirect in the same cycle as data_ok in WAIT: the data is dropped. Next state is REQ with `pc`=`redirect_pc`.
- PC arithmetic: 32-bit, `pc+4` wraps modulo 2^32. `redirect_pc[1:0]` is forced to 0 internally.
- No delay-slot knowledge lives in this block. Redirect timing is the issuer's responsibility.
- Exactly one outstanding bus transaction at any time.

## Timing
- Reset values: `state`=BOOT, `pc`=`RESET_PC`, `ireq_valid`=0, `ireq_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `pend_valid`=0, `discard`=0.
- Reset asserted in any state returns to BOOT immediately. Any outstanding bus response after reset is the bus's responsibility.
- Cycle 1 after reset release: REQ, `ireq_valid`=1.
- Zero-wait bus (addr_ok in REQ, data_ok next cycle): 2 cycles from `ireq_valid` rising to `out_valid` rising. With addr_ok and data_ok in the same cycle: 1 cycle.
- HOLD→REQ takes one cycle. Peak throughput is 1 instruction per 3 cycles with a zero-wait bus.
- `out_*` are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset release with zero-wait bus and `out_ready`=1: requests go out at 0xbfc00000, 0xbfc00004, 0xbfc00008 in order. `out_pc` matches each and `out_instr` equals the returned data.
- Decode stall (`out_ready`=0 for 5 cycles in HOLD): `out_valid`=1 and `out_instr`/`out_pc` unchanged throughout. No new `ireq_valid` is issued.
- `redirect_valid` with `redirect_pc`=0x80001000 while in WAIT: the returned word is never presented. The next `ireq_addr` is 0x80001000.
- Redirect to 0x80002000 while `addr_ok`=0 in REQ at 0xbfc00004: `ireq_addr` stays 0xbfc00004 until accepted. The data is dropped, then the fetch goes to 0x80002000.
- Redirect and `out_ready` together in HOLD with `out_pc`=0xbfc00008: that instruction is handed over once. The next fetch is from `redirect_pc`.
- Reset asserted mid-WAIT: `out_valid`/`ireq_valid` drop to 0 asynchronously. After release, fetch restarts at `RESET_PC`.
